ctrl_sequencer: RTL and testbench
=================================

# ctrl_sequencer

Parametrised hardwired control sequencer that replaces hand-scripted T0–T5 stimulus with an FSM driving the datapath control strobes. One instruction executes per `Start`: fetch, memory wait, decode, execute. It sits between the memory/IR side and the existing datapath, which it drives through one-hot register select vectors and the named bus/latch strobes. It generalises the fixed ALU sequence to:

- a configurable register count;
- bounded memory wait states;
- unary, binary and 64-bit-result (MUL/DIV) instruction lengths;
- illegal-opcode and timeout fault reporting.

## Interface
Parameters:
- `REG_CNT`, 16, number of general registers (2..16); field values `>= REG_CNT` are illegal.
- `WAIT_TIMEOUT`, 15, maximum low `MemReady` cycles in T1 before fault (1..255).

Ports:
- `Clock`  in  1  sole clock, rising edge.
- `Reset`  in  1  synchronous, active-high.
- `Start`  in  1  begin one instruction; sampled in IDLE and DONE only.
- `IR`  in  32  instruction register contents; fields are `op[31:27]`, `Ra[26:23]`, `Rb[22:19]`, `Rc[18:15]`.
- `MemReady`  in  1  memory read data valid.
- `Rin`  out  REG_CNT  one-hot register load.
- `Rout`  out  REG_CNT  one-hot register drive.
- `PCout`, `PCin`, `IncPC`, `MARin`, `MDRin`, `MDRout`, `Read`, `IRin`, `Yin`, `Zin`, `Zlowout`, `ZHighout`, `LOin`, `HIin`  out  1 each  datapath strobes.
- `operation`  out  5  ALU op code.
- `Busy`  out  1  any state except IDLE, DONE, FAULT.
- `Done`  out  1  high for the single DONE cycle.
- `Fault`  out  1  sticky error flag.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, DONE, FAULT.
- All outputs are decoded from the registered state plus `IR` fields. They are zero in IDLE and FAULT.
- Opcodes:
  - binary: ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011.
  - 64-bit: DIV 01111, MUL 10000.
  - unary: NEG 10001, NOT 10010.
  - Every other opcode is illegal.
- Per-state behaviour:
  - T0: `PCout`, `MARin`, `IncPC`, `Zin`.
  - T1: `Zlowout`, `PCin` (first cycle only), `Read`, `MDRin`. Held until `MemReady` is 1.
  - T2: `MDRout`, `IRin`.
  - T3:
    - binary: `Rout[Rb]`, `Yin`.
    - MUL/DIV: `Rout[Ra]`, `Yin`.
    - unary ops skip T3 (T2→T4).
  - T4: `operation` = opcode, `Zin`, and:
    - binary: `Rout[Rc]`.
    - unary and MUL/DIV: `Rout[Rb]`.
  - T5:
    - binary and unary: `Zlowout`, `Rin[Ra]`.
    - MUL/DIV: `Zlowout`, `LOin`.
  - T6 (MUL/DIV only): `ZHighout`, `HIin`.
  - DONE: `Done` = 1.
- Transitions:
  - IDLE→T0 on `Start`.
  - T1→T2 on `MemReady`.
  - T5→DONE, except MUL/DIV go T5→T6→DONE.
  - DONE→T0 if `Start` is 1 (back-to-back), else DONE→IDLE.
- Decode and fault:
  - Decode happens at the T2→next edge, using `IR` as loaded.
  - Illegal opcode, or any used register field `>= REG_CNT`, at that edge → FAULT.
  - FAULT is left only by `Reset`; `Start` is ignored there. `Fault` is 1 in FAULT.
- Wait counter:
  - 8 bits; cleared on T1 entry.
  - Increments each T1 cycle with `MemReady` = 0.
  - When it reaches `WAIT_TIMEOUT` with `MemReady` still 0 → FAULT.
- `Start` while `Busy` is ignored.
- `Rin`/`Rout` are always zero or one-hot.

## Timing
- `Reset` at an edge forces IDLE and clears the counter and `Fault`, from any state including mid-T1. All outputs are 0 after that edge.
- Latency with `MemReady` = 1 during T1:
  - `Start` sampled at edge n → T0 in cycle n+1, T1 n+2, T2 n+3.
  - Binary: `Done` in cycle n+7.
  - Unary: `Done` in cycle n+6.
  - MUL/DIV: `Done` in cycle n+8.
- Each low `MemReady` cycle in T1 adds one cycle.
- `operation` is valid only in T4 and is 0 elsewhere.
- No combinational path from `Start` or `MemReady` to any output.

## Configuration
- `SEQ_MULDIV_EN`:
  - Defined: MUL/DIV are legal, T6 exists, and `LOin`/`HIin`/`ZHighout` are driven.
  - Undefined: MUL/DIV decode as illegal → FAULT; T6 is not built; `LOin`, `HIin` and `ZHighout` are tied 0.

## Structure
- Shared package `ctrl_pkg`:
  - state enum;
  - opcode constants;
  - IR field bit-position constants;
  - `is_unary` / `is_muldiv` / `is_legal` functions.
- One sub-module: `onehot_dec` (binary index → REG_CNT one-hot with enable). It is instantiated twice, for `Rin` and `Rout`.

## Test plan
- **AND, IR = 0x2A2B8000, `MemReady` = 1:** T3 `Rout` = 0x0020 with `Yin`. T4 `Rout` = 0x0080 with `operation` = 00101 and `Zin`. T5 `Rin` = 0x0010 with `Zlowout`. `Done` 7 cycles after `Start`.
- **NOT R2,R3 (IR = 0x91180000):** T2→T4 directly; T4 `Rout` = 0x0008; T5 `Rin` = 0x0004; `Done` 6 cycles after `Start`.
- **`MemReady` low 3 cycles in T1:** `Read` held 4 cycles, `PCin` only in the first; `Done` 10 cycles after `Start`. **`MemReady` held low:** FAULT after 15 wait cycles, `Fault` = 1, `Start` ignored until `Reset`.
- **MUL R0,R1 (IR = 0x80080000) with `SEQ_MULDIV_EN`:** T5 `LOin`, T6 `ZHighout` + `HIin`, `Done` at n+8. Without the macro: FAULT after T2.
- **`REG_CNT` = 8, IR `Rc` = 9:** FAULT after T2, no `Rin` ever asserted.
- **`Reset` asserted during T4:** all outputs 0 next cycle, state IDLE. **`Start` held through DONE:** next instruction's T0 immediately follows DONE.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types, opcode constants and instruction-class helpers for the control sequencer.
// Define SEQ_MULDIV_EN to make MUL/DIV legal opcodes (adds the T6 high-word step).
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

`ifdef SEQ_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    function automatic logic is_binary(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_SHL);
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return is_binary(op) || is_unary(op) || (MULDIV_EN && is_muldiv(op));
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Binary register index to one-hot select vector; all zero when disabled or out of range.
module onehot_dec #(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       index,
    input  logic             enable,
    output logic [WIDTH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (enable && (index == 4'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/wait/decode/execute sequencer driving the datapath strobes.
// Define SEQ_MULDIV_EN to build the MUL/DIV path (T6, LOin, HIin, ZHighout).
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int REG_CNT      = 16,
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [31:0]        IR,
    input  logic               MemReady,
    output logic [REG_CNT-1:0] Rin,
    output logic [REG_CNT-1:0] Rout,
    output logic               PCout,
    output logic               PCin,
    output logic               IncPC,
    output logic               MARin,
    output logic               MDRin,
    output logic               MDRout,
    output logic               Read,
    output logic               IRin,
    output logic               Yin,
    output logic               Zin,
    output logic               Zlowout,
    output logic               ZHighout,
    output logic               LOin,
    output logic               HIin,
    output logic [4:0]         operation,
    output logic               Busy,
    output logic               Done,
    output logic               Fault
);

    state_t     state;
    logic [7:0] wait_cnt;
    logic [4:0] op_q;
    logic [3:0] ra_q, rb_q, rc_q;

    logic [4:0] ir_op;
    logic [3:0] ir_ra, ir_rb, ir_rc;
    logic       regs_ok, decode_ok;
    logic       rin_en, rout_en;
    logic [3:0] rin_idx, rout_idx;
    logic       unused_ir_bits;

    assign ir_op = IR[OP_MSB:OP_LSB];
    assign ir_ra = IR[RA_MSB:RA_LSB];
    assign ir_rb = IR[RB_MSB:RB_LSB];
    assign ir_rc = IR[RC_MSB:RC_LSB];
    assign unused_ir_bits = ^IR[RC_LSB-1:0];

    // Rc is only a register operand for binary ops, so only they can fault on it.
    assign regs_ok = (int'(ir_ra) < REG_CNT) && (int'(ir_rb) < REG_CNT) &&
                     (!is_binary(ir_op) || (int'(ir_rc) < REG_CNT));
    assign decode_ok = is_legal(ir_op) && regs_ok;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            op_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
        end else begin
            case (state)
                S_IDLE: if (Start) state <= S_T0;
                S_T0: begin
                    state    <= S_T1;
                    wait_cnt <= '0;
                end
                S_T1: begin
                    if (MemReady) begin
                        state <= S_T2;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt + 8'd1 == 8'(WAIT_TIMEOUT)) state <= S_FAULT;
                    end
                end
                S_T2: begin
                    op_q <= ir_op;
                    ra_q <= ir_ra;
                    rb_q <= ir_rb;
                    rc_q <= ir_rc;
                    if (!decode_ok)          state <= S_FAULT;
                    else if (is_unary(ir_op)) state <= S_T4;
                    else                      state <= S_T3;
                end
                S_T3: state <= S_T4;
                S_T4: state <= S_T5;
`ifdef SEQ_MULDIV_EN
                S_T5: state <= is_muldiv(op_q) ? S_T6 : S_DONE;
                S_T6: state <= S_DONE;
`else
                S_T5: state <= S_DONE;
`endif
                S_DONE:  state <= Start ? S_T0 : S_IDLE;
                S_FAULT: state <= S_FAULT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes depend only on the registered state and the fields latched at decode.
    always_comb begin
        rin_en    = 1'b0;
        rin_idx   = ra_q;
        rout_en   = 1'b0;
        rout_idx  = rb_q;
        PCout     = 1'b0;
        PCin      = 1'b0;
        IncPC     = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        Read      = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        Zlowout   = 1'b0;
        ZHighout  = 1'b0;
        LOin      = 1'b0;
        HIin      = 1'b0;
        operation = '0;
        case (state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = (wait_cnt == 8'd0);
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                rout_en  = 1'b1;
                rout_idx = is_muldiv(op_q) ? ra_q : rb_q;
                Yin      = 1'b1;
            end
            S_T4: begin
                operation = op_q;
                Zin       = 1'b1;
                rout_en   = 1'b1;
                rout_idx  = is_binary(op_q) ? rc_q : rb_q;
            end
            S_T5: begin
                Zlowout = 1'b1;
`ifdef SEQ_MULDIV_EN
                if (is_muldiv(op_q)) LOin = 1'b1;
                else                 rin_en = 1'b1;
`else
                rin_en = 1'b1;
`endif
            end
`ifdef SEQ_MULDIV_EN
            S_T6: begin
                ZHighout = 1'b1;
                HIin     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign Busy  = (state != S_IDLE) && (state != S_DONE) && (state != S_FAULT);
    assign Done  = (state == S_DONE);
    assign Fault = (state == S_FAULT);

    onehot_dec #(.WIDTH(REG_CNT)) u_rin_dec (
        .index  (rin_idx),
        .enable (rin_en),
        .onehot (Rin)
    );

    onehot_dec #(.WIDTH(REG_CNT)) u_rout_dec (
        .index  (rout_idx),
        .enable (rout_en),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: vector table, hand-written corner sequences and random instructions
// checked cycle by cycle against a trace model built from the instruction-class rules.
module tb_ctrl_sequencer;

    localparam int WAIT_TO = 15;
`ifdef SEQ_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic pcout, pcin, incpc, marin, mdrin, mdrout, read, irin;
        logic yin, zin, zlowout, zhighout, loin, hiin;
        logic [4:0] op;
        logic busy, done, fault;
    } out_t;

    typedef struct {
        logic [31:0] ir;
        int          waits;
        int          exp_done;
        bit          exp_fault;
    } vec_t;

    logic        Clock = 1'b0;
    logic        Reset, Start, MemReady;
    logic [31:0] IR;
    logic [15:0] Rin, Rout;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
    logic Yin, Zin, Zlowout, ZHighout, LOin, HIin;
    logic [4:0]  operation;
    logic        Busy, Done, Fault;
    logic [7:0]  rin8, rout8;
    logic        fault8;
    logic [21:0] unused8;

    int   n_checks = 0;
    int   n_pass   = 0;
    out_t exp_q[$];

    always #5 Clock = ~Clock;

    ctrl_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .IR(IR), .MemReady(MemReady),
        .Rin(Rin), .Rout(Rout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .ZHighout(ZHighout), .LOin(LOin), .HIin(HIin),
        .operation(operation), .Busy(Busy), .Done(Done), .Fault(Fault)
    );

    ctrl_sequencer #(.REG_CNT(8), .WAIT_TIMEOUT(15)) dut8 (
        .Clock(Clock), .Reset(Reset), .Start(Start), .IR(IR), .MemReady(MemReady),
        .Rin(rin8), .Rout(rout8), .PCout(unused8[0]), .PCin(unused8[1]), .IncPC(unused8[2]),
        .MARin(unused8[3]), .MDRin(unused8[4]), .MDRout(unused8[5]), .Read(unused8[6]),
        .IRin(unused8[7]), .Yin(unused8[8]), .Zin(unused8[9]), .Zlowout(unused8[10]),
        .ZHighout(unused8[11]), .LOin(unused8[12]), .HIin(unused8[13]),
        .operation(unused8[18:14]), .Busy(unused8[19]), .Done(unused8[20]), .Fault(fault8)
    );

    function automatic out_t sample();
        out_t s;
        s.rin = Rin;       s.rout = Rout;
        s.pcout = PCout;   s.pcin = PCin;     s.incpc = IncPC;   s.marin = MARin;
        s.mdrin = MDRin;   s.mdrout = MDRout; s.read = Read;     s.irin = IRin;
        s.yin = Yin;       s.zin = Zin;       s.zlowout = Zlowout;
        s.zhighout = ZHighout; s.loin = LOin; s.hiin = HIin;
        s.op = operation;  s.busy = Busy;     s.done = Done;     s.fault = Fault;
        return s;
    endfunction

    function automatic out_t t0_rec();
        out_t r = '0;
        r.pcout = 1; r.marin = 1; r.incpc = 1; r.zin = 1; r.busy = 1;
        return r;
    endfunction

    function automatic out_t fault_rec();
        out_t r = '0;
        r.fault = 1;
        return r;
    endfunction

    // Expected output trace, one record per cycle from T0 up to DONE or the first FAULT cycle.
    function automatic void build_expected(input logic [31:0] ir, input int waits);
        out_t r;
        logic [4:0] op = ir[31:27];
        int ra = int'(ir[26:23]);
        int rb = int'(ir[22:19]);
        int rc = int'(ir[18:15]);
        bit bin = (op >= 5'd3) && (op <= 5'd11);
        bit una = (op == 5'd17) || (op == 5'd18);
        bit md  = (op == 5'd15) || (op == 5'd16);
        bit legal = bin || una || (md && MULDIV_EN);
        bit timeout = (waits >= WAIT_TO);
        int n_t1 = timeout ? WAIT_TO : waits + 1;
        exp_q.delete();
        exp_q.push_back(t0_rec());
        for (int k = 0; k < n_t1; k++) begin
            r = '0; r.zlowout = 1; r.read = 1; r.mdrin = 1; r.busy = 1; r.pcin = (k == 0);
            exp_q.push_back(r);
        end
        if (timeout) begin
            exp_q.push_back(fault_rec());
            return;
        end
        r = '0; r.mdrout = 1; r.irin = 1; r.busy = 1;
        exp_q.push_back(r);
        if (!legal) begin
            exp_q.push_back(fault_rec());
            return;
        end
        if (!una) begin
            r = '0; r.yin = 1; r.busy = 1; r.rout = 16'(1) << (bin ? rb : ra);
            exp_q.push_back(r);
        end
        r = '0; r.op = op; r.zin = 1; r.busy = 1; r.rout = 16'(1) << (bin ? rc : rb);
        exp_q.push_back(r);
        r = '0; r.zlowout = 1; r.busy = 1;
        if (md) r.loin = 1; else r.rin = 16'(1) << ra;
        exp_q.push_back(r);
        if (md) begin
            r = '0; r.zhighout = 1; r.hiin = 1; r.busy = 1;
            exp_q.push_back(r);
        end
        r = '0; r.done = 1;
        exp_q.push_back(r);
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic reset_dut();
        Start = 1'b0;
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        check_output("reset_outputs", 64'(sample()), 64'(out_t'('0)));
    endtask

    // Issues one instruction and compares every cycle; Start is randomised while busy.
    task automatic apply_stimulus(input logic [31:0] ir, input int waits, input bit hold,
                                  input int abort_at, output int done_at, output bit faulted);
        int   rd = 0;
        out_t act;
        build_expected(ir, waits);
        done_at = 0;
        faulted = 0;
        IR = ir;
        Start = 1'b1;
        MemReady = 1'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge Clock); #1;
            Start = 1'($urandom);
            act = sample();
            check_output($sformatf("cycle%0d ir=%h", i + 1, ir), 64'(act), 64'(exp_q[i]));
            if (act.done) done_at = i + 1;
            if (act.fault) faulted = 1;
            if (exp_q[i].read) begin
                rd++;
                MemReady = (rd > waits);
            end else begin
                MemReady = 1'($urandom);
            end
            if (i == exp_q.size() - 1) Start = hold;
            if (i + 1 == abort_at) break;
        end
    endtask

    task automatic finish_instr(input bit faulted);
        if (faulted) begin
            Start = 1'b1;
            repeat (3) begin
                @(posedge Clock); #1;
                check_output("fault_sticky", 64'(sample()), 64'(fault_rec()));
            end
            reset_dut();
        end else begin
            Start = 1'b0;
            @(posedge Clock); #1;
            check_output("idle_after_done", 64'(sample()), 64'(out_t'('0)));
        end
    endtask

    initial begin
        vec_t vecs[9];
        int   d;
        bit   f;
        logic [31:0] rir;

        Reset = 1'b0; Start = 1'b0; MemReady = 1'b0; IR = '0;
        vecs[0] = '{32'h2A2B8000, 0, 7, 1'b0};
        vecs[1] = '{32'h91180000, 0, 6, 1'b0};
        vecs[2] = '{32'h2A2B8000, 3, 10, 1'b0};
        vecs[3] = '{32'h80080000, 0, MULDIV_EN ? 8 : 0, !MULDIV_EN};
        vecs[4] = '{32'h78000000, 1, MULDIV_EN ? 9 : 0, !MULDIV_EN};
        vecs[5] = '{32'h2A2B8000, 40, 0, 1'b1};
        vecs[6] = '{32'h00000000, 0, 0, 1'b1};
        vecs[7] = '{32'h18918000, 0, 7, 1'b0};
        vecs[8] = '{32'h88000000, 2, 8, 1'b0};

        reset_dut();
        foreach (vecs[k]) begin
            apply_stimulus(vecs[k].ir, vecs[k].waits, 1'b0, 0, d, f);
            check_output($sformatf("latency vec%0d", k), 64'(d), 64'(vecs[k].exp_done));
            check_output($sformatf("fault vec%0d", k), 64'(f), 64'(vecs[k].exp_fault));
            finish_instr(f);
        end

        // Reset in T4 returns straight to idle with all strobes low.
        apply_stimulus(32'h2A2B8000, 0, 1'b0, 5, d, f);
        reset_dut();

        // Start held through DONE launches the next fetch immediately.
        apply_stimulus(32'h18918000, 0, 1'b1, 0, d, f);
        @(posedge Clock); #1;
        Start = 1'b0;
        check_output("back_to_back_t0", 64'(sample()), 64'(t0_rec()));
        reset_dut();

        // Eight-register build: Rc = 9 must fault after T2 without ever loading a register.
        IR = 32'h18948000;
        MemReady = 1'b1;
        Start = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge Clock); #1;
            Start = 1'b0;
            check_output($sformatf("reg8_rin cycle%0d", i), 64'(rin8), 64'd0);
            check_output($sformatf("reg8_fault cycle%0d", i), 64'(fault8), 64'(i >= 4));
        end
        reset_dut();

        for (int n = 0; n < 40; n++) begin
            int w;
            rir = $urandom;
            w = ($urandom_range(0, 9) == 0) ? WAIT_TO + 1 : int'($urandom_range(0, 3));
            apply_stimulus(rir, w, 1'b0, 0, d, f);
            finish_instr(f);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
